// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - multi-channel switch debouncer with edge, long-press and auto-repeat pulses
// Optional auto-repeat is built only when DEBOUNCE_REPEAT_EN is defined.
module button_debouncer #(
    parameter int NCH     = 4,
    parameter int NDELAY  = 2000000,
    parameter int NHOLD   = 50000000,
    parameter int NREPEAT = 10000000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] noisy,
    output logic [NCH-1:0] clean,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic [NCH-1:0] long_press,
    output logic [NCH-1:0] repeat_pulse
);

    localparam int CW = (NDELAY > 2) ? $clog2(NDELAY) : 1;
    localparam int HW = $clog2(NHOLD + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(NDELAY - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(NHOLD - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(NHOLD);

    logic [NCH-1:0] sync1;
    logic [NCH-1:0] s;
    logic [CW-1:0]  cnt      [NCH];
    logic [CW-1:0]  cnt_nxt  [NCH];
    logic [NCH-1:0] clean_nxt;
    logic [HW-1:0]  hold     [NCH];

    always_comb begin
        clean_nxt = clean;
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt[i] = '0;
            if (s[i] != clean[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    clean_nxt[i] = s[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Gating on clean_nxt lets a fall cancel a long-press in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1      <= '0;
            s          <= '0;
            clean      <= '0;
            rise       <= '0;
            fall       <= '0;
            long_press <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i]  <= '0;
                hold[i] <= '0;
            end
        end else begin
            sync1 <= noisy;
            s     <= sync1;
            clean <= clean_nxt;
            rise  <= clean_nxt & ~clean;
            fall  <= ~clean_nxt & clean;
            for (int i = 0; i < NCH; i++) begin
                cnt[i]        <= cnt_nxt[i];
                long_press[i] <= 1'b0;
                if (!clean[i] || !clean_nxt[i]) begin
                    hold[i] <= '0;
                end else if (hold[i] != HOLD_SAT) begin
                    hold[i] <= hold[i] + HW'(1);
                    if (hold[i] == HOLD_LAST) begin
                        long_press[i] <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RW = (NREPEAT > 2) ? $clog2(NREPEAT) : 1;
    localparam logic [RW-1:0] RPT_LAST = RW'(NREPEAT - 1);

    logic [RW-1:0] rpt_cnt [NCH];

    // Repeat period starts counting from the cycle long_press fires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            repeat_pulse <= '0;
            for (int i = 0; i < NCH; i++) begin
                rpt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                repeat_pulse[i] <= 1'b0;
                if (hold[i] != HOLD_SAT || !clean_nxt[i]) begin
                    rpt_cnt[i] <= '0;
                end else if (rpt_cnt[i] == RPT_LAST) begin
                    rpt_cnt[i]      <= '0;
                    repeat_pulse[i] <= 1'b1;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
                end
            end
        end
    end
`else
    assign repeat_pulse = '0;

    if (NREPEAT < 2) begin : g_nrepeat_out_of_range
    end
`endif

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent input channels (1..32).
REQ-002 SHALL have parameter NDELAY, default 2000000, consecutive stable cycles required to accept a new level (>=2).
REQ-003 SHALL have parameter NHOLD, default 50000000, cycles a channel must stay clean-high before a long-press event (>NDELAY).
REQ-004 SHALL have parameter NREPEAT, default 10000000, auto-repeat period in cycles after a long press (>=2).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-007 SHALL have port noisy  input  NCH  raw asynchronous switch inputs, bit i = channel i.
REQ-008 SHALL have port clean  output  NCH  debounced level per channel.
REQ-009 SHALL have port rise  output  NCH  one-cycle pulse when clean[i] goes 0->1.
REQ-010 SHALL have port fall  output  NCH  one-cycle pulse when clean[i] goes 1->0.
REQ-011 SHALL have port long_press  output  NCH  one-cycle pulse after NHOLD cycles of clean[i]=1.
REQ-012 SHALL have port repeat  output  NCH  one-cycle auto-repeat pulse (see Configuration).

Function
REQ-013 Each channel SHALL pass noisy[i] through a two-flop synchronizer; its second stage is s[i].
REQ-014 Per channel, a stability counter of width clog2(NDELAY) SHALL: clear when s[i]==clean[i]; when s[i]!=clean[i] and count==NDELAY-1, load clean[i]<=s[i] and clear; otherwise increment.
REQ-015 Any single cycle of agreement (glitch back) SHALL clear the counter; a new level is accepted only after NDELAY consecutive disagreeing samples.
REQ-016 Latency noisy edge -> clean edge SHALL be exactly NDELAY+2 cycles for a clean step input.
REQ-017 rise[i]/fall[i] SHALL be registered and asserted in the same cycle clean[i] shows its new value, for exactly one cycle.
REQ-018 Per channel, a hold counter SHALL clear whenever clean[i]==0 and increment while clean[i]==1, saturating after the long-press event.
REQ-019 long_press[i] SHALL pulse once, in the cycle the hold counter reaches NHOLD-1 (NHOLD cycles after rise[i]); no further long_press until clean[i] returns to 0.
REQ-020 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-021 A fall[i] SHALL abort any pending long-press or repeat sequence on that channel the same cycle.

Reset
REQ-022 While rst_n==0 at a clk edge, synchronizer flops, counters, clean, rise, fall, long_press and repeat SHALL all load 0.
REQ-023 Reset asserted mid-debounce or mid-hold SHALL discard progress; after release, an input held 1 SHALL produce clean=1 and rise=1 exactly NDELAY+2 cycles after the first edge with rst_n==1.
REQ-024 No output SHALL pulse in the cycle reset is released.

Configuration
REQ-025 Macro DEBOUNCE_REPEAT_EN SHALL control auto-repeat.
REQ-026 With DEBOUNCE_REPEAT_EN defined, after long_press[i] a repeat counter SHALL pulse repeat[i] every NREPEAT cycles (first pulse NREPEAT cycles after long_press[i]) while clean[i]==1.
REQ-027 Without DEBOUNCE_REPEAT_EN, repeat SHALL be constant 0 and the repeat counters SHALL not exist; all other behaviour unchanged.

Verification (NCH=4, NDELAY=8, NHOLD=32, NREPEAT=16)
REQ-028 noisy[0] 0->1 at cycle 10, held -> clean[0]=1 and rise[0]=1 for one cycle at cycle 20; other channels stay 0.
REQ-029 noisy[1] toggled every 5 cycles for 100 cycles, then 0 -> clean[1] stays 0, no rise/fall pulses.
REQ-030 noisy[2] high from cycle 0 for 60 cycles -> rise at 10, long_press at 42, repeat at 58 only with DEBOUNCE_REPEAT_EN; fall at 70.
REQ-031 noisy=4'b1111 at cycle 5 -> rise=4'b1111 in one cycle at cycle 15.
REQ-032 noisy[3] high, rst_n low for cycles 14-16 -> all outputs 0 during reset; rise[3] at cycle 27 after release at cycle 17.
